// File: rtl/reg_writeback_ctrl_if.sv
// Handshake and register-file bundle between the writeback requesters and the
// write-side controller. The controller sits on the slave modport.
interface reg_writeback_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic [3:0]  Caddr;
    logic [15:0] C;
    logic        load;
    logic [3:0]  Aaddr;
    logic [3:0]  Baddr;
    logic [15:0] A_rf;
    logic [15:0] B_rf;
    logic [15:0] A;
    logic [15:0] B;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output Aaddr, Baddr, A_rf, B_rf,
        input  mem_ready, alu_ready, Caddr, C, load, A, B
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  Aaddr, Baddr, A_rf, B_rf,
        output mem_ready, alu_ready, Caddr, C, load, A, B
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// In-order writeback FIFO for the 16x16 register file: merges mem/ALU writes,
// drains one per cycle and forwards pending values onto the A/B read ports.
module reg_writeback_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nClear,
    reg_writeback_ctrl_if.slave  bus
);

    localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [3:0]    entryAddr_q [DEPTH];
    logic [15:0]   entryData_q [DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW:0]   free;
    logic [PW-1:0] aluSlot;
    logic [PW-1:0] scanSlot;
    logic          memPush, aluPush, pop;

    // Readies look only at the occupancy at the start of the cycle, so a pop
    // happening on this edge never lends a slot to a new request.
    always_comb begin
        free          = FULL - count_q;
        bus.mem_ready = nClear & (free >= (PW+1)'(1));
        bus.alu_ready = nClear & (free >= (bus.mem_valid ? (PW+1)'(2) : (PW+1)'(1)));
        memPush       = bus.mem_valid & bus.mem_ready & (bus.mem_addr != 4'd0);
        aluPush       = bus.alu_valid & bus.alu_ready & (bus.alu_addr != 4'd0);
        pop           = (count_q != '0);
        aluSlot       = wrPtr_q + PW'(memPush);
        wrPtr_d       = wrPtr_q + PW'(memPush) + PW'(aluPush);
        rdPtr_d       = rdPtr_q + PW'(pop);
        count_d       = count_q + (PW+1)'(memPush) + (PW+1)'(aluPush) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // The mem entry lands first so it retires ahead of a same-cycle ALU write.
    always_ff @(posedge clk) begin
        if (memPush) begin
            entryAddr_q[wrPtr_q] <= bus.mem_addr;
            entryData_q[wrPtr_q] <= bus.mem_data;
        end
        if (aluPush) begin
            entryAddr_q[aluSlot] <= bus.alu_addr;
            entryData_q[aluSlot] <= bus.alu_data;
        end
    end

    always_comb begin
        bus.load  = (count_q != '0);
        bus.Caddr = bus.load ? entryAddr_q[rdPtr_q] : 4'd0;
        bus.C     = bus.load ? entryData_q[rdPtr_q] : 16'd0;
    end

    // Scan oldest to youngest so the last hit is the youngest pending value.
    always_comb begin
        bus.A    = bus.A_rf;
        bus.B    = bus.B_rf;
        scanSlot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanSlot = rdPtr_q + PW'(i);
            if ((PW+1)'(i) < count_q) begin
                if ((bus.Aaddr != 4'd0) && (entryAddr_q[scanSlot] == bus.Aaddr)) begin
                    bus.A = entryData_q[scanSlot];
                end
                if ((bus.Baddr != 4'd0) && (entryAddr_q[scanSlot] == bus.Baddr)) begin
                    bus.B = entryData_q[scanSlot];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl: accepted writes are queued in order
// and compared against the register-file port every cycle.
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic nClear;
    int   compared   = 0;
    int   mismatched = 0;
    wr_t  sbQ[$];

    reg_writeback_ctrl_if bus();

    reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .nClear (nClear),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Retirement monitor: sbQ mirrors the FIFO after each edge, so its head
    // must be on Caddr/C whenever it is non-empty, and the port idle otherwise.
    always @(negedge clk) begin
        if ($time > 0) begin
            compared++;
            if (sbQ.size() > 0) begin
                if (bus.load !== 1'b1 || bus.Caddr !== sbQ[0].addr || bus.C !== sbQ[0].data) begin
                    mismatched++;
                    $display("[TB] FAIL retire: got load=%b Caddr=%0d C=%h, need load=1 Caddr=%0d C=%h",
                             bus.load, bus.Caddr, bus.C, sbQ[0].addr, sbQ[0].data);
                end
            end else begin
                if (bus.load !== 1'b0 || bus.Caddr !== 4'd0 || bus.C !== 16'd0) begin
                    mismatched++;
                    $display("[TB] FAIL idle_port: got load=%b Caddr=%0d C=%h, need load=0 Caddr=0 C=0000",
                             bus.load, bus.Caddr, bus.C);
                end
            end
        end
    end

    // One cycle of stimulus: drive requests mid-cycle, derive the expected
    // readies and bypass values from the scoreboard, then advance the model.
    task automatic runCycle(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                            input logic av, input logic [3:0] aa, input logic [15:0] ad,
                            output logic expMr, output logic expAr,
                            output logic [15:0] expA, output logic [15:0] expB);
        int free;
        @(negedge clk);
        #1;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        #1;
        free  = DEPTH - sbQ.size();
        expMr = nClear && (free >= 1);
        expAr = nClear && (free >= (mv ? 2 : 1));
        expA  = bus.A_rf;
        expB  = bus.B_rf;
        foreach (sbQ[i]) begin
            if (bus.Aaddr != 4'd0 && sbQ[i].addr == bus.Aaddr) expA = sbQ[i].data;
            if (bus.Baddr != 4'd0 && sbQ[i].addr == bus.Baddr) expB = sbQ[i].data;
        end
        if (sbQ.size() > 0) void'(sbQ.pop_front());
        if (mv && expMr && ma != 4'd0) sbQ.push_back('{addr: ma, data: md});
        if (av && expAr && aa != 4'd0) sbQ.push_back('{addr: aa, data: ad});
    endtask

    task automatic test_reset();
        nClear = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        bus.Aaddr = 4'd2;
        bus.A_rf  = 16'h1357;
        #1;
        compared++;
        if (bus.load !== 1'b0 || bus.Caddr !== 4'd0 || bus.C !== 16'd0 ||
            bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got load=%b Caddr=%0d C=%h mr=%b ar=%b, need all 0",
                     bus.load, bus.Caddr, bus.C, bus.mem_ready, bus.alu_ready);
        end
        compared++;
        if (bus.A !== 16'h1357) begin
            mismatched++;
            $display("[TB] FAIL reset_bypass: got A=%h, need 1357", bus.A);
        end
        @(negedge clk);
        #1;
        nClear = 1'b1;
        #1;
        compared++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release_ready: got mr=%b ar=%b, need 1 1", bus.mem_ready, bus.alu_ready);
        end
    endtask

    task automatic test_single_write();
        logic mr, ar;
        logic [15:0] ea, eb;
        runCycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'hBEEF, mr, ar, ea, eb);
        compared++;
        if (bus.alu_ready !== ar || ar !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_ready: got ar=%b, need 1", bus.alu_ready);
        end
        runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        compared++;
        if (bus.load !== 1'b1 || bus.Caddr !== 4'd5 || bus.C !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL single_write: got load=%b Caddr=%0d C=%h, need 1 5 BEEF",
                     bus.load, bus.Caddr, bus.C);
        end
        runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        compared++;
        if (bus.load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_once: got load=%b, need 0", bus.load);
        end
    endtask

    task automatic test_dual_accept();
        logic mr, ar;
        logic [15:0] ea, eb;
        bus.Aaddr = 4'd3;
        bus.A_rf  = 16'h5555;
        runCycle(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222, mr, ar, ea, eb);
        compared++;
        if (bus.mem_ready !== mr || bus.alu_ready !== ar) begin
            mismatched++;
            $display("[TB] FAIL dual_ready: got mr=%b ar=%b, need %b %b", bus.mem_ready, bus.alu_ready, mr, ar);
        end
        for (int k = 0; k < 3; k++) begin
            runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
            compared++;
            if (bus.A !== ea) begin
                mismatched++;
                $display("[TB] FAIL dual_bypass%0d: got A=%h, need %h", k, bus.A, ea);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic mr, ar;
        logic [15:0] ea, eb;
        runCycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hFFFF, mr, ar, ea, eb);
        compared++;
        if (bus.alu_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL zero_ready: got ar=%b, need 1", bus.alu_ready);
        end
        for (int k = 0; k < 2; k++) begin
            runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
            compared++;
            if (bus.load !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL zero_discard%0d: got load=%b, need 0", k, bus.load);
            end
        end
    endtask

    task automatic test_backpressure();
        logic mr, ar;
        logic [15:0] ea, eb;
        int issued;
        logic mv, av;
        logic [3:0] ma, aa;
        issued = 0;
        for (int cyc = 0; cyc < 60 && issued < 20; cyc++) begin
            mv = 1'b1;
            av = (issued + 1 < 20);
            ma = 4'((issued % 15) + 1);
            aa = 4'(((issued + 1) % 15) + 1);
            bus.Aaddr = 4'((cyc * 7) % 16);
            bus.A_rf  = 16'(16'hC000 + cyc);
            runCycle(mv, ma, 16'(16'hA000 + issued), av, aa, 16'(16'hA000 + issued + 1),
                     mr, ar, ea, eb);
            compared++;
            if (bus.mem_ready !== mr || bus.alu_ready !== ar) begin
                mismatched++;
                $display("[TB] FAIL bp_ready c%0d: got mr=%b ar=%b, need %b %b",
                         cyc, bus.mem_ready, bus.alu_ready, mr, ar);
            end
            compared++;
            if (bus.A !== ea) begin
                mismatched++;
                $display("[TB] FAIL bp_bypass c%0d: got A=%h, need %h", cyc, bus.A, ea);
            end
            if (mr) issued++;
            if (av && ar) issued++;
        end
        for (int k = 0; k < DEPTH + 2; k++) begin
            runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        end
    endtask

    task automatic test_bypass_miss();
        logic mr, ar;
        logic [15:0] ea, eb;
        runCycle(1'b1, 4'd4, 16'h4444, 1'b1, 4'd7, 16'h7777, mr, ar, ea, eb);
        bus.Aaddr = 4'd7;
        bus.A_rf  = 16'h0000;
        bus.Baddr = 4'd9;
        bus.B_rf  = 16'h0A0A;
        runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        compared++;
        if (bus.B !== 16'h0A0A || bus.B !== eb) begin
            mismatched++;
            $display("[TB] FAIL bypass_miss: got B=%h, need 0A0A", bus.B);
        end
        compared++;
        if (bus.A !== 16'h7777) begin
            mismatched++;
            $display("[TB] FAIL bypass_hit: got A=%h, need 7777", bus.A);
        end
        bus.Aaddr = 4'd0;
        bus.A_rf  = 16'h1234;
        bus.Baddr = 4'd7;
        runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        compared++;
        if (bus.A !== 16'h1234) begin
            mismatched++;
            $display("[TB] FAIL bypass_zero: got A=%h, need 1234", bus.A);
        end
        compared++;
        if (bus.B !== 16'h7777) begin
            mismatched++;
            $display("[TB] FAIL bypass_b_hit: got B=%h, need 7777", bus.B);
        end
        runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
    endtask

    task automatic test_reset_mid();
        logic mr, ar;
        logic [15:0] ea, eb;
        runCycle(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, mr, ar, ea, eb);
        runCycle(1'b1, 4'd3, 16'hCCCC, 1'b1, 4'd6, 16'hDDDD, mr, ar, ea, eb);
        compared++;
        if (sbQ.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL mid_setup: pending=%0d, need 3", sbQ.size());
        end
        @(negedge clk);
        #1;
        bus.mem_valid = 1'b1;
        bus.alu_valid = 1'b1;
        nClear = 1'b0;
        #1;
        compared++;
        if (bus.load !== 1'b0 || bus.Caddr !== 4'd0 || bus.C !== 16'd0 ||
            bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got load=%b Caddr=%0d C=%h mr=%b ar=%b, need all 0",
                     bus.load, bus.Caddr, bus.C, bus.mem_ready, bus.alu_ready);
        end
        sbQ.delete();
        for (int k = 0; k < 2; k++) begin
            runCycle(1'b1, 4'd8, 16'h8888, 1'b1, 4'd9, 16'h9999, mr, ar, ea, eb);
            compared++;
            if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_hold%0d: got mr=%b ar=%b, need 0 0", k, bus.mem_ready, bus.alu_ready);
            end
        end
        @(negedge clk);
        #1;
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        nClear = 1'b1;
        #1;
        compared++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_release: got mr=%b ar=%b, need 1 1", bus.mem_ready, bus.alu_ready);
        end
        for (int k = 0; k < 4; k++) begin
            runCycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, mr, ar, ea, eb);
        end
    endtask

    initial begin
        nClear        = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 4'd0;
        bus.mem_data  = 16'd0;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = 4'd0;
        bus.alu_data  = 16'd0;
        bus.Aaddr     = 4'd0;
        bus.Baddr     = 4'd0;
        bus.A_rf      = 16'd0;
        bus.B_rf      = 16'd0;

        test_reset();
        test_single_write();
        test_dual_accept();
        test_zero_reg();
        test_backpressure();
        test_bypass_miss();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
